// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply (radix-2 shift-add) / divide (restoring) unit for the execute stage.
// Latency: start in cycle N -> md_done in N+34; divide-by-zero / signed overflow in N+2.
// Backpressure: holds the pipeline with md_stall until the md_done cycle; md_flush aborts to IDLE.
module ex_muldiv #(
    parameter int XLEN          = 32,
    parameter bit DIV_ZERO_FAST = 1'b1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            md_start,
    input  logic [2:0]      md_op,
    input  logic [XLEN-1:0] md_rs1,
    input  logic [XLEN-1:0] md_rs2,
    input  logic [4:0]      md_rd_idx,
    input  logic            md_flush,
    output logic            md_stall,
    output logic            md_busy,
    output logic            md_done,
    output logic [XLEN-1:0] md_result,
    output logic [4:0]      md_wr_idx
);

    localparam int              CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIXUP,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [2:0]        op_q;
    logic [XLEN-1:0]   opb_q;
    logic [2*XLEN-1:0] acc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              neg_q;
    logic [4:0]        rd_q;

    logic              accept;
    logic              sgn1, sgn2, s1, s2;
    logic [XLEN-1:0]   abs1, abs2;
    logic              div0, ovf, fast;
    logic [XLEN-1:0]   opb_init;
    logic [2*XLEN-1:0] acc_init;
    logic              neg_init;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_sh;
    logic              geq;
    logic [2*XLEN-1:0] acc_step;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   div_sel;
    logic [XLEN-1:0]   fix_res;

    assign accept    = md_start & (state == S_IDLE) & ~md_flush;
    assign md_busy   = (state != S_IDLE);
    assign md_done   = (state == S_DONE);
    assign md_stall  = accept | (md_busy & ~md_done);

    // Operand conditioning: magnitudes and sign bookkeeping at accept time.
    always_comb begin
        sgn1     = (md_op == 3'd1) | (md_op == 3'd2) | (md_op == 3'd4) | (md_op == 3'd6);
        sgn2     = (md_op == 3'd1) | (md_op == 3'd4) | (md_op == 3'd6);
        s1       = sgn1 & md_rs1[XLEN-1];
        s2       = sgn2 & md_rs2[XLEN-1];
        abs1     = s1 ? -md_rs1 : md_rs1;
        abs2     = s2 ? -md_rs2 : md_rs2;
        div0     = (md_rs2 == '0);
        ovf      = ~md_op[0] & (md_rs1 == INT_MIN) & (md_rs2 == {XLEN{1'b1}});
        fast     = DIV_ZERO_FAST & md_op[2] & (div0 | ovf);
        opb_init = abs1;
        acc_init = {{XLEN{1'b0}}, abs2};
        neg_init = s1 ^ s2;
        if (md_op[2]) begin
            opb_init = abs2;
            // Divide by zero keeps the quotient at all-ones regardless of operand signs.
            neg_init = md_op[1] ? s1 : ((s1 ^ s2) & ~div0);
            if (fast)
                acc_init = div0 ? {abs1, {XLEN{1'b1}}} : {{XLEN{1'b0}}, INT_MIN};
            else
                acc_init = {{XLEN{1'b0}}, abs1};
        end
    end

    // One iteration: shift-add for multiply, shift-compare-subtract for divide.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
        rem_sh   = acc_q[2*XLEN-1:XLEN-1];
        geq      = (rem_sh >= {1'b0, opb_q});
        acc_step = {mul_sum, acc_q[XLEN-1:1]};
        if (op_q[2])
            acc_step = {(geq ? (rem_sh[XLEN-1:0] - opb_q) : rem_sh[XLEN-1:0]),
                        acc_q[XLEN-2:0], geq};
    end

    always_comb begin
        prod_fix = neg_q ? -acc_q : acc_q;
        div_sel  = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
        fix_res  = (op_q == 3'd0) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        if (op_q[2])
            fix_res = neg_q ? -div_sel : div_sel;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = fast ? S_FIXUP : S_CALC;
            S_CALC:  if (cnt_q == CNT_LAST) state_nxt = S_FIXUP;
            S_FIXUP: state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (md_flush)
            state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            op_q      <= '0;
            opb_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            rd_q      <= '0;
            md_result <= '0;
            md_wr_idx <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q  <= md_op;
                        opb_q <= opb_init;
                        acc_q <= acc_init;
                        cnt_q <= '0;
                        neg_q <= neg_init;
                        rd_q  <= md_rd_idx;
                    end
                end
                S_CALC: begin
                    acc_q <= acc_step;
                    cnt_q <= cnt_q + 1'b1;
                end
                S_FIXUP: begin
                    // A flushed op must leave the previously published result intact.
                    if (!md_flush) begin
                        md_result <= fix_res;
                        md_wr_idx <= rd_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Randomized and directed bench for ex_muldiv against an arithmetic RV32M reference.
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rstn;
    logic        md_start;
    logic [2:0]  md_op;
    logic [31:0] md_rs1;
    logic [31:0] md_rs2;
    logic [4:0]  md_rd_idx;
    logic        md_flush;
    logic        md_stall;
    logic        md_busy;
    logic        md_done;
    logic [31:0] md_result;
    logic [4:0]  md_wr_idx;

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] last_exp = '0;
    logic [4:0]  last_rd  = '0;

    ex_muldiv #(.XLEN(32), .DIV_ZERO_FAST(1'b1)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .md_start  (md_start),
        .md_op     (md_op),
        .md_rs1    (md_rs1),
        .md_rs2    (md_rs2),
        .md_rd_idx (md_rd_idx),
        .md_flush  (md_flush),
        .md_stall  (md_stall),
        .md_busy   (md_busy),
        .md_done   (md_done),
        .md_result (md_result),
        .md_wr_idx (md_wr_idx)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        int ia, ib;
        logic ov;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        ia = $signed(a);
        ib = $signed(b);
        ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = 64'(ua * ub); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ov) return 32'h8000_0000;
                return 32'(ia / ib);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ov) return 32'h0;
                return 32'(ia % ib);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        if (op >= 3'd4 && (b == 0 || ((op == 3'd4 || op == 3'd6) &&
                                      a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 2;
        return 34;
    endfunction

    // Called just after a rising edge; returns just after the edge that leaves DONE.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd);
        int k;
        bit seen;
        bit stall_ok;
        logic [31:0] exp;
        exp = model(op, a, b);
        md_start  = 1'b1;
        md_op     = op;
        md_rs1    = a;
        md_rs2    = b;
        md_rd_idx = rd;
        @(negedge clk);
        check({tag, "_stall_start"}, {31'b0, md_stall}, 32'd1);
        @(posedge clk);
        #1;
        md_start  = 1'b0;
        md_rs1    = $urandom;
        md_rs2    = $urandom;
        md_rd_idx = 5'($urandom);
        md_op     = 3'($urandom);
        k = 1;
        seen = 0;
        stall_ok = 1;
        while (k <= 60 && !seen) begin
            @(negedge clk);
            if (md_done) begin
                seen = 1;
            end else begin
                if (!md_stall) stall_ok = 0;
                @(posedge clk);
                #1;
                k++;
            end
        end
        check({tag, "_latency"}, seen ? 32'(k) : 32'hFFFF_FFFF, 32'(exp_latency(op, a, b)));
        check({tag, "_stall_hold"}, {31'b0, stall_ok}, 32'd1);
        check({tag, "_result"}, md_result, exp);
        check({tag, "_wr_idx"}, {27'b0, md_wr_idx}, {27'b0, rd});
        if (seen) check({tag, "_stall_done"}, {31'b0, md_stall}, 32'd0);
        last_exp = exp;
        last_rd  = rd;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int dones;
        rstn      = 1'b0;
        md_start  = 1'b0;
        md_op     = '0;
        md_rs1    = '0;
        md_rs2    = '0;
        md_rd_idx = '0;
        md_flush  = 1'b0;
        #2;
        check("rst_busy",   {31'b0, md_busy},  32'd0);
        check("rst_done",   {31'b0, md_done},  32'd0);
        check("rst_stall",  {31'b0, md_stall}, 32'd0);
        check("rst_result", md_result,         32'd0);
        check("rst_wr_idx", {27'b0, md_wr_idx}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;

        run_op("mul_7xm3",    3'd0, 32'd7,          32'hFFFF_FFFD, 5'd3);
        run_op("mulh_min",    3'd1, 32'h8000_0000,  32'h8000_0000, 5'd4);
        run_op("mulhu_max",   3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd5);
        run_op("mulhsu_max",  3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd6);
        run_op("div_m7_2",    3'd4, 32'hFFFF_FFF9,  32'd2,         5'd7);
        run_op("rem_m7_2",    3'd6, 32'hFFFF_FFF9,  32'd2,         5'd8);
        run_op("divu_100_7",  3'd5, 32'd100,        32'd7,         5'd9);
        run_op("remu_100_7",  3'd7, 32'd100,        32'd7,         5'd10);
        run_op("div_5_0",     3'd4, 32'd5,          32'd0,         5'd11);
        run_op("rem_5_0",     3'd6, 32'd5,          32'd0,         5'd12);
        run_op("div_ovf",     3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd13);
        run_op("rem_ovf",     3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd14);
        run_op("divu_x_0",    3'd5, 32'h1234_5678,  32'd0,         5'd15);
        run_op("remu_x_0",    3'd7, 32'h1234_5678,  32'd0,         5'd16);
        run_op("div_neg_0",   3'd4, 32'hFFFF_FF00,  32'd0,         5'd17);

        // Flush in CALC iteration 10 together with a competing start.
        md_start = 1'b1; md_op = 3'd0; md_rs1 = 32'd123; md_rs2 = 32'd456; md_rd_idx = 5'd20;
        @(posedge clk);
        #1;
        md_start = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        @(negedge clk);
        check("flush_busy_before", {31'b0, md_busy}, 32'd1);
        md_flush = 1'b1; md_start = 1'b1; md_op = 3'd5; md_rs1 = 32'd9; md_rs2 = 32'd3;
        md_rd_idx = 5'd21;
        @(posedge clk);
        #1;
        md_flush = 1'b0; md_start = 1'b0;
        @(negedge clk);
        check("flush_busy_after",  {31'b0, md_busy},  32'd0);
        check("flush_stall_after", {31'b0, md_stall}, 32'd0);
        dones = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (md_done) dones++;
        end
        check("flush_no_done",  32'(dones), 32'd0);
        check("flush_result",   md_result, last_exp);
        check("flush_wr_idx",   {27'b0, md_wr_idx}, {27'b0, last_rd});

        // Flush and start together in IDLE: nothing accepted.
        md_flush = 1'b1; md_start = 1'b1;
        @(negedge clk);
        check("idle_flush_stall", {31'b0, md_stall}, 32'd0);
        @(posedge clk);
        #1;
        md_flush = 1'b0; md_start = 1'b0;
        @(negedge clk);
        check("idle_flush_busy", {31'b0, md_busy}, 32'd0);
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of CALC.
        md_start = 1'b1; md_op = 3'd5; md_rs1 = 32'd1000; md_rs2 = 32'd3; md_rd_idx = 5'd22;
        @(posedge clk);
        #1;
        md_start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        rstn = 1'b0;
        #1;
        check("arst_busy",   {31'b0, md_busy},  32'd0);
        check("arst_stall",  {31'b0, md_stall}, 32'd0);
        check("arst_result", md_result,         32'd0);
        check("arst_wr_idx", {27'b0, md_wr_idx}, 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        run_op("post_rst_mul", 3'd0, 32'h0001_0003, 32'h0000_0101, 5'd23);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, 5'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
